// File: rtl/key_entry_pkg.sv
// Shared definitions for the key entry controller.
// Holds the command keycodes, the controller state type, the legal-time
// digit limits, and a helper that checks the three significant digits of
// an entered HH:MM value.
package key_entry_pkg;

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;

  // Limits for a legal 24-hour HH:MM entry.
  localparam logic [3:0] MAX_HR_TENS     = 4'd2;
  localparam logic [3:0] MAX_HR_UNITS_20 = 4'd3;  // units limit when tens == 2
  localparam logic [3:0] MAX_MIN_TENS    = 4'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } state_t;

  // The minute units digit is always a decimal digit, so it never affects
  // legality and is not an argument.
  function automatic logic legal_time(input logic [3:0] ms_hr,
                                      input logic [3:0] ls_hr,
                                      input logic [3:0] ms_min);
    logic hr_ok;
    hr_ok = (ms_hr < MAX_HR_TENS) ||
            ((ms_hr == MAX_HR_TENS) && (ls_hr <= MAX_HR_UNITS_20));
    return hr_ok && (ms_min <= MAX_MIN_TENS);
  endfunction

endpackage

// File: rtl/key_timeout_counter.sv
// Idle timer for the key entry controller.
// Counts enabled cycles since the last clear. expire is raised
// combinationally in the enabled cycle whose increment would bring the
// count to TIMEOUT_CYCLES-1, so the owner can act on that same edge.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   clear          : synchronous clear to 0 (wins over enable)
//   enable         : count this cycle
//   expire         : timeout reached this cycle
module key_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // The count never needs to hold more than TIMEOUT_CYCLES-2.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES - 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expire = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad time entry controller.
// Collects up to four digits into an HH:MM shift buffer and, on an ALARM or
// TIME command, either pulses the matching load strobe (legal time) or
// entry_error. An entry left idle for TIMEOUT_CYCLES is abandoned with an
// entry_timeout pulse. All outputs are registered.
// Ports:
//   clock, reset_n       : system clock, async active-low reset
//   key, key_valid       : keycode and its one-cycle qualifier
//   key_ms_hr..key_ls_min: entered digits (held after load/error)
//   show_new_time        : high while an entry is in progress
//   load_new_a/load_new_c: legal alarm/current time pulses
//   entry_error          : command rejected pulse
//   entry_timeout        : entry abandoned pulse
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       show_new_time,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       entry_error,
  output logic       entry_timeout
);

  state_t state;
  logic   is_digit, is_cmd;
  logic   tmr_clear, tmr_en, tmr_expire;
  logic   buf_legal;

  assign is_digit = key_valid && (key <= 4'd9);
  assign is_cmd   = key_valid && ((key == KEY_ALARM) || (key == KEY_TIME));

  // Reserved keys fall through to tmr_en, so they count as idle cycles.
  assign tmr_clear = (state == ST_IDLE) || is_digit;
  assign tmr_en    = (state == ST_ENTRY) && !is_digit && !is_cmd;

  assign buf_legal = legal_time(key_ms_hr, key_ls_hr, key_ms_min);

  key_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      key_ms_hr     <= 4'h0;
      key_ls_hr     <= 4'h0;
      key_ms_min    <= 4'h0;
      key_ls_min    <= 4'h0;
      show_new_time <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
    end else begin
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Commands and reserved keys are ignored here; buffer stays held.
          if (is_digit) begin
            key_ms_hr     <= 4'h0;
            key_ls_hr     <= 4'h0;
            key_ms_min    <= 4'h0;
            key_ls_min    <= key;
            state         <= ST_ENTRY;
            show_new_time <= 1'b1;
          end
        end
        ST_ENTRY: begin
          if (is_digit) begin
            key_ms_hr  <= key_ls_hr;
            key_ls_hr  <= key_ms_min;
            key_ms_min <= key_ls_min;
            key_ls_min <= key;
          end else if (is_cmd) begin
            if (!buf_legal)             entry_error <= 1'b1;
            else if (key == KEY_ALARM)  load_new_a  <= 1'b1;
            else                        load_new_c  <= 1'b1;
            state         <= ST_IDLE;
            show_new_time <= 1'b0;
          end else if (tmr_expire) begin
            key_ms_hr     <= 4'h0;
            key_ls_hr     <= 4'h0;
            key_ms_min    <= 4'h0;
            key_ls_min    <= 4'h0;
            entry_timeout <= 1'b1;
            state         <= ST_IDLE;
            show_new_time <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          show_new_time <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10, idle cycles in ENTRY before the entry is abandoned (range 2..65535).
REQ-002 clock  input  1  single system clock, all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 key  input  4  keycode: 4'h0-4'h9 digit, 4'hA ALARM command, 4'hB TIME command, 4'hC-4'hF reserved.
REQ-005 key_valid  input  1  one-cycle strobe qualifying key; key is sampled only when key_valid=1.
REQ-006 key_ms_hr  output  4  entered hour tens digit, registered.
REQ-007 key_ls_hr  output  4  entered hour units digit, registered.
REQ-008 key_ms_min  output  4  entered minute tens digit, registered.
REQ-009 key_ls_min  output  4  entered minute units digit, registered.
REQ-010 show_new_time  output  1  high while in ENTRY; selects key digits on the display driver.
REQ-011 load_new_a  output  1  one-cycle pulse: key digits are a valid new alarm time.
REQ-012 load_new_c  output  1  one-cycle pulse: key digits are a valid new current time.
REQ-013 entry_error  output  1  one-cycle pulse: command rejected, digits not a legal time.
REQ-014 entry_timeout  output  1  one-cycle pulse: entry abandoned by timeout.

Function
REQ-015 Two states SHALL exist: IDLE, ENTRY; all outputs SHALL be registered.
REQ-016 IDLE + digit d: buffer SHALL become {0,0,0,d}, timer cleared, next state ENTRY.
REQ-017 IDLE + command or reserved key: SHALL be ignored; no pulse, buffer unchanged.
REQ-018 ENTRY + digit d: buffer SHALL shift left (ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=d), oldest digit discarded, timer cleared.
REQ-019 ENTRY + ALARM: if buffer legal, load_new_a SHALL pulse, else entry_error SHALL pulse; next state IDLE either way.
REQ-020 ENTRY + TIME: same as REQ-019 with load_new_c.
REQ-021 Legal time SHALL mean ms_hr<=2, ls_hr<=3 when ms_hr==2, ms_min<=5 (fewer than 4 digits entered is legal, leading zeros implied).
REQ-022 Pulses (REQ-019/020) SHALL assert in the cycle after the command key is sampled, for exactly one cycle.
REQ-023 Buffer SHALL be held after a load or error until the next digit in IDLE, so consumers may sample it during and after the pulse.
REQ-024 ENTRY, no key_valid: timer SHALL increment each cycle; on reaching TIMEOUT_CYCLES-1 the block SHALL clear buffer to 0, pulse entry_timeout, go IDLE.
REQ-025 Key strobe in the same cycle the timer expires SHALL take priority; no timeout.
REQ-026 Reserved keys in ENTRY SHALL be ignored and SHALL NOT clear the timer.
REQ-027 show_new_time SHALL equal (state==ENTRY), falling in the same cycle a load/error/timeout pulse rises.
REQ-028 At most one of load_new_a, load_new_c, entry_error, entry_timeout SHALL be high in any cycle.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, timer 0, all key digits 4'h0, all other outputs 0.
REQ-030 Reset mid-entry SHALL discard the partial entry without any pulse.
REQ-031 First key sampled SHALL be on the first rising edge with reset_n high.

Structure
REQ-032 Shared package key_entry_pkg SHALL hold keycode constants (KEY_ALARM=4'hA, KEY_TIME=4'hB), the state type, and the legal-time limits (2,3,5).
REQ-033 The timer SHALL be one sub-module key_timeout_counter (clear, enable, expire), width from TIMEOUT_CYCLES.
REQ-034 Top SHALL contain the FSM, shift buffer, and validity check.

Verification
REQ-035 Digits 1,2,3,4 then ALARM -> key=12:34, load_new_a one cycle, show_new_time 1->0.
REQ-036 Digits 2,5,0,0 then TIME -> entry_error pulse, no load_new_c, buffer 25:00 held.
REQ-037 Digits 1,2,3,4,5 then TIME -> buffer 23:45, load_new_c pulse.
REQ-038 Digit 7 then silence, TIMEOUT_CYCLES=10 -> entry_timeout pulse 10 cycles after the strobe, buffer 00:00, IDLE.
REQ-039 Digit at timer expiry cycle -> no timeout, shift occurs; reset_n low mid-entry -> all outputs 0, no pulse.
REQ-040 ALARM in IDLE and key 4'hE in ENTRY -> no state, buffer, or pulse change; timer keeps counting.
